// File: rtl/bp_update_scheduler.sv
// Port arbiter and read-modify-write sequencer for a single-ported PHT of 2-bit counters.
// Lookups own the port; queued feedback updates fill the idle cycles. Also sweeps the table after reset.
module bp_update_scheduler #(
  parameter int unsigned IDX_W = 8,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_req_valid,
  input  logic [IDX_W-1:0]         i_req_index,
  output logic                     o_pred_valid,
  output logic                     o_pred_taken,
  input  logic                     i_fb_valid,
  input  logic [IDX_W-1:0]         i_fb_index,
  input  logic                     i_fb_taken,
  input  logic                     i_fb_mispredict,
  output logic                     o_tbl_en,
  output logic                     o_tbl_we,
  output logic [IDX_W-1:0]         o_tbl_addr,
  output logic [1:0]               o_tbl_wdata,
  input  logic [1:0]               i_tbl_rdata,
  output logic                     o_busy,
  output logic [$clog2(DEPTH):0]   o_fb_count,
  output logic [CNT_W-1:0]         o_lookup_cnt,
  output logic [CNT_W-1:0]         o_miss_cnt,
  output logic [CNT_W-1:0]         o_drop_cnt
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FullCnt = (PW+1)'(DEPTH);

  typedef enum logic [1:0] {StInit, StIdle, StRd, StWr} state_e;

  state_e           state_q;
  logic [IDX_W-1:0] sweep_q;
  logic [IDX_W-1:0] fifo_idx_q [DEPTH];
  logic             fifo_tk_q  [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic [IDX_W-1:0] wk_idx_q;
  logic             wk_taken_q;
  logic [1:0]       wk_cnt_q;
  logic             pred_valid_q, pred_tbl_q;
  logic [CNT_W-1:0] lookup_cnt_q, miss_cnt_q, drop_cnt_q;

  logic       pop, push, drop, full;
  logic [1:0] next_cnt;

  always_comb begin
    full = (count_q == FullCnt);
    pop  = rst_n && (state_q == StIdle) && (count_q != '0) && !i_req_valid;
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    push = rst_n && i_fb_valid && (!full || pop);
    drop = rst_n && i_fb_valid && full && !pop;

    if (wk_taken_q) next_cnt = (i_tbl_rdata == 2'd3) ? 2'd3 : i_tbl_rdata + 2'd1;
    else            next_cnt = (i_tbl_rdata == 2'd0) ? 2'd0 : i_tbl_rdata - 2'd1;
  end

  always_comb begin
    o_tbl_en    = 1'b0;
    o_tbl_we    = 1'b0;
    o_tbl_addr  = '0;
    o_tbl_wdata = 2'b00;
    if (rst_n) begin
      if (state_q == StInit) begin
        o_tbl_en    = 1'b1;
        o_tbl_we    = 1'b1;
        o_tbl_addr  = sweep_q;
        o_tbl_wdata = 2'b01;
      end else if (i_req_valid) begin
        o_tbl_en   = 1'b1;
        o_tbl_addr = i_req_index;
      end else if (pop) begin
        o_tbl_en   = 1'b1;
        o_tbl_addr = fifo_idx_q[rd_ptr_q];
      end else if (state_q == StWr) begin
        o_tbl_en    = 1'b1;
        o_tbl_we    = 1'b1;
        o_tbl_addr  = wk_idx_q;
        o_tbl_wdata = wk_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StInit;
      sweep_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wk_idx_q     <= '0;
      wk_taken_q   <= 1'b0;
      wk_cnt_q     <= 2'b00;
      pred_valid_q <= 1'b0;
      pred_tbl_q   <= 1'b0;
      lookup_cnt_q <= '0;
      miss_cnt_q   <= '0;
      drop_cnt_q   <= '0;
    end else begin
      unique case (state_q)
        StInit: begin
          sweep_q <= sweep_q + IDX_W'(1);
          if (sweep_q == '1) state_q <= StIdle;
        end
        StIdle: begin
          if (pop) begin
            wk_idx_q   <= fifo_idx_q[rd_ptr_q];
            wk_taken_q <= fifo_tk_q[rd_ptr_q];
            state_q    <= StRd;
          end
        end
        StRd: begin
          wk_cnt_q <= next_cnt;
          state_q  <= StWr;
        end
        StWr: begin
          if (!i_req_valid) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase

      if (push) begin
        fifo_idx_q[wr_ptr_q] <= i_fb_index;
        fifo_tk_q[wr_ptr_q]  <= i_fb_taken;
        wr_ptr_q             <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);

      unique case ({push, pop})
        2'b10:   count_q <= count_q + (PW+1)'(1);
        2'b01:   count_q <= count_q - (PW+1)'(1);
        default: count_q <= count_q;
      endcase

      pred_valid_q <= i_req_valid;
      pred_tbl_q   <= (state_q != StInit);

      if (i_req_valid && lookup_cnt_q != '1) lookup_cnt_q <= lookup_cnt_q + CNT_W'(1);
      if (i_fb_valid && i_fb_mispredict && miss_cnt_q != '1)
        miss_cnt_q <= miss_cnt_q + CNT_W'(1);
      if (drop && drop_cnt_q != '1) drop_cnt_q <= drop_cnt_q + CNT_W'(1);
    end
  end

  assign o_pred_valid = pred_valid_q;
  assign o_pred_taken = pred_valid_q & pred_tbl_q & i_tbl_rdata[1];
  assign o_busy       = rst_n && ((state_q != StIdle) || (count_q != '0));
  assign o_fb_count   = count_q;
  assign o_lookup_cnt = lookup_cnt_q;
  assign o_miss_cnt   = miss_cnt_q;
  assign o_drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_bp_update_scheduler.sv
// Bench for bp_update_scheduler: directed scenarios plus randomized bursts checked against
// a sequential counter model of the PHT, with a behavioural 1-cycle-latency table attached.
module tb_bp_update_scheduler;
  localparam int unsigned IDX_W = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             req_valid;
  logic [IDX_W-1:0] req_index;
  logic             pred_valid, pred_taken;
  logic             fb_valid, fb_taken, fb_mis;
  logic [IDX_W-1:0] fb_index;
  logic             tbl_en, tbl_we;
  logic [IDX_W-1:0] tbl_addr;
  logic [1:0]       tbl_wdata;
  logic [1:0]       tbl_rdata = 2'b00;
  logic             busy;
  logic [2:0]       fb_count;
  logic [CNT_W-1:0] lookup_cnt, miss_cnt, drop_cnt;

  bp_update_scheduler #(.IDX_W(IDX_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req_valid(req_valid), .i_req_index(req_index),
    .o_pred_valid(pred_valid), .o_pred_taken(pred_taken),
    .i_fb_valid(fb_valid), .i_fb_index(fb_index), .i_fb_taken(fb_taken),
    .i_fb_mispredict(fb_mis),
    .o_tbl_en(tbl_en), .o_tbl_we(tbl_we), .o_tbl_addr(tbl_addr), .o_tbl_wdata(tbl_wdata),
    .i_tbl_rdata(tbl_rdata),
    .o_busy(busy), .o_fb_count(fb_count),
    .o_lookup_cnt(lookup_cnt), .o_miss_cnt(miss_cnt), .o_drop_cnt(drop_cnt)
  );

  // Behavioural single-ported table with one cycle of read latency.
  logic [1:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 2'b00;
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) mem[tbl_addr] <= tbl_wdata;
      else        tbl_rdata     <= mem[tbl_addr];
    end
  end

  // Access log as {we, addr, wdata}; reads log wdata as 0.
  logic [10:0] log_q [$];
  int viol = 0;
  always @(negedge clk) begin
    if (rst_n && tbl_en) log_q.push_back({tbl_we, tbl_addr, tbl_we ? tbl_wdata : 2'b00});
    if (!tbl_en && tbl_we) viol++;
    if (!rst_n && tbl_en) viol++;
  end

  // Expected statistics straight from the counting rules.
  longint exp_lk = 0, exp_miss = 0, exp_drop = 0;
  always @(posedge clk) begin
    if (!rst_n) begin
      exp_lk   <= 0;
      exp_miss <= 0;
    end else begin
      if (req_valid) exp_lk <= exp_lk + 1;
      if (fb_valid && fb_mis) exp_miss <= exp_miss + 1;
    end
  end

  int checks = 0, errors = 0;
  logic [1:0] model [256];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_drain(input string tag);
    int n = 0;
    while (busy && n < 200) begin
      step();
      n++;
    end
    settle();
    chk(tag, busy, 0);
  endtask

  task automatic check_init_log(input string tag);
    int bad = 0;
    for (int i = 0; i < log_q.size(); i++)
      if (log_q[i] !== {1'b1, 8'(i), 2'b01}) bad++;
    chk({tag, "_len"}, log_q.size(), 256);
    chk({tag, "_seq"}, bad, 0);
  endtask

  function automatic logic [1:0] upd(input logic [1:0] c, input logic t);
    int v = int'(c) + (t ? 1 : -1);
    if (v > 3) v = 3;
    if (v < 0) v = 0;
    return 2'(v);
  endfunction

  task automatic lookup_check(input string tag, input logic [7:0] idx, input logic exp);
    req_valid = 1'b1;
    req_index = idx;
    step();
    req_valid = 1'b0;
    settle();
    chk({tag, "_pv"}, pred_valid, 1);
    chk({tag, "_pt"}, pred_taken, exp);
  endtask

  initial begin
    logic [10:0] exp_seq [4];
    int bad;
    rst_n = 1'b0; req_valid = 1'b0; req_index = '0;
    fb_valid = 1'b0; fb_index = '0; fb_taken = 1'b0; fb_mis = 1'b0;

    // Reset and INIT sweep
    step(); step(); settle();
    chk("rst_tbl_en", tbl_en, 0);
    chk("rst_pred_valid", pred_valid, 0);
    chk("rst_fb_count", fb_count, 0);
    chk("rst_lookup_cnt", lookup_cnt, 0);
    rst_n = 1'b1;
    log_q.delete();
    repeat (256) step();
    check_init_log("init");
    settle();
    chk("idle_busy", busy, 0);
    chk("idle_en", tbl_en, 0);

    // Lookup after INIT reads the swept value
    req_valid = 1'b1; req_index = 8'd5;
    settle();
    chk("lk_en", tbl_en, 1);
    chk("lk_we", tbl_we, 0);
    chk("lk_addr", tbl_addr, 5);
    step();
    req_valid = 1'b0;
    settle();
    chk("lk5_pv", pred_valid, 1);
    chk("lk5_pt", pred_taken, 0);
    chk("lk_cnt1", lookup_cnt, 1);

    // Two taken feedbacks to idx 7: R7 W2 R7 W3
    log_q.delete();
    fb_valid = 1'b1; fb_index = 8'd7; fb_taken = 1'b1; fb_mis = 1'b0;
    step(); step();
    fb_valid = 1'b0;
    repeat (8) step();
    chk("t2_len", log_q.size(), 4);
    exp_seq = '{{1'b0, 8'd7, 2'd0}, {1'b1, 8'd7, 2'd2}, {1'b0, 8'd7, 2'd0}, {1'b1, 8'd7, 2'd3}};
    for (int i = 0; i < 4 && i < log_q.size(); i++) chk("t2_acc", log_q[i], exp_seq[i]);
    lookup_check("t2_lk7", 8'd7, 1'b1);

    // Write held off by lookups during WR
    fb_valid = 1'b1; fb_index = 8'd9; fb_taken = 1'b1;
    step();
    fb_valid = 1'b0;
    step(); step();
    req_valid = 1'b1; req_index = 8'd20;
    for (int k = 0; k < 3; k++) begin
      settle();
      chk("t3_we", tbl_we, 0);
      chk("t3_addr", tbl_addr, 20);
      if (k > 0) chk("t3_pv", pred_valid, 1);
      step();
    end
    req_valid = 1'b0;
    settle();
    chk("t3_wr", {tbl_en, tbl_we, tbl_addr, tbl_wdata}, {1'b1, 1'b1, 8'd9, 2'd2});
    chk("t3_pv_last", pred_valid, 1);
    chk("t3_pt_last", pred_taken, 0);
    step();

    // Six feedbacks while lookups hold the port: 4 accepted, 2 dropped
    req_valid = 1'b1; req_index = 8'd50;
    for (int i = 0; i < 6; i++) begin
      fb_valid = 1'b1; fb_index = 8'(30 + i); fb_taken = 1'b1; fb_mis = 1'b1;
      step();
    end
    fb_valid = 1'b0; fb_mis = 1'b0;
    exp_drop = 2;
    settle();
    chk("t4_count", fb_count, 4);
    chk("t4_drop", drop_cnt, exp_drop);
    chk("t4_miss", miss_cnt, 6);

    // Full FIFO, pop and push in the same cycle
    req_valid = 1'b0;
    fb_valid = 1'b1; fb_index = 8'd36; fb_taken = 1'b1;
    step();
    fb_valid = 1'b0;
    settle();
    chk("t5_drop", drop_cnt, exp_drop);
    chk("t5_count", fb_count, 4);
    wait_drain("t5_drain");
    bad = 0;
    for (int i = 30; i <= 36; i++)
      if (mem[i] !== ((i == 34 || i == 35) ? 2'd1 : 2'd2)) bad++;
    chk("t5_table", bad, 0);

    // Reset during RD abandons the write and restarts INIT
    fb_valid = 1'b1; fb_index = 8'd40; fb_taken = 1'b1;
    step();
    fb_valid = 1'b0;
    step();
    rst_n = 1'b0;
    settle();
    chk("t6_rst_en", tbl_en, 0);
    step();
    rst_n = 1'b1;
    exp_drop = 0;
    log_q.delete();
    settle();
    chk("t6_count", fb_count, 0);
    chk("t6_stats", {lookup_cnt, miss_cnt, drop_cnt}, 0);
    chk("t6_pv", pred_valid, 0);
    chk("t6_init0", {tbl_en, tbl_we, tbl_addr, tbl_wdata}, {1'b1, 1'b1, 8'd0, 2'd1});
    // Lookup during INIT: no port use, predicts not-taken
    repeat (100) step();
    req_valid = 1'b1; req_index = 8'd7;
    settle();
    chk("t6_init_we", tbl_we, 1);
    step();
    req_valid = 1'b0;
    settle();
    chk("t6_init_pv", pred_valid, 1);
    chk("t6_init_pt", pred_taken, 0);
    repeat (155) step();
    check_init_log("t6_init");
    chk("t6_mem40", mem[40], 1);

    // Saturation at idx 2
    for (int i = 0; i < 3; i++) begin
      fb_valid = 1'b1; fb_index = 8'd2; fb_taken = 1'b0; fb_mis = 1'b1;
      step();
    end
    fb_valid = 1'b0; fb_mis = 1'b0;
    wait_drain("t7_drain_nt");
    chk("t7_sat0", mem[2], 0);
    for (int i = 0; i < 5; i++) begin
      fb_valid = 1'b1; fb_index = 8'd2; fb_taken = 1'b1;
      step();
    end
    fb_valid = 1'b0;
    wait_drain("t7_drain_t");
    chk("t7_sat3", mem[2], 3);
    lookup_check("t7_lk2", 8'd2, 1'b1);

    // Randomized bursts against a sequential counter model
    for (int i = 0; i < 256; i++) model[i] = 2'd1;
    model[2] = 2'd3;
    for (int b = 0; b < 20; b++) begin
      int nfb = $urandom_range(1, 4);
      int sent = 0;
      int cyc = 0;
      while (sent < nfb && cyc < 400) begin
        req_valid = 1'($urandom_range(0, 1));
        req_index = 8'($urandom_range(0, 255));
        fb_valid  = ($urandom_range(0, 2) == 0);
        if (fb_valid) begin
          fb_index = 8'($urandom_range(0, 15));
          fb_taken = 1'($urandom_range(0, 1));
          fb_mis   = 1'($urandom_range(0, 1));
          model[fb_index] = upd(model[fb_index], fb_taken);
          sent++;
        end
        step();
        cyc++;
      end
      fb_valid = 1'b0; req_valid = 1'b0; fb_mis = 1'b0;
      wait_drain("rnd_drain");
      bad = 0;
      for (int i = 0; i < 16; i++) if (mem[i] !== model[i]) bad++;
      chk("rnd_table", bad, 0);
      begin
        logic [7:0] li;
        li = 8'($urandom_range(0, 15));
        lookup_check("rnd_lk", li, model[li][1]);
      end
    end

    settle();
    chk("final_lookup_cnt", lookup_cnt, exp_lk);
    chk("final_miss_cnt", miss_cnt, exp_miss);
    chk("final_drop_cnt", drop_cnt, exp_drop);
    chk("final_port_viol", viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bp_update_scheduler.md
Name: bp_update_scheduler

Overview:
- Arbiter and sequencer for a single-ported, 1-cycle-latency pattern history table (PHT) of 2-bit saturating counters used by the branch predictor.
- Shares the table port between two requesters:
  - decode-stage prediction lookups, which have strict priority;
  - execute-stage feedback updates, which are queued and applied as read-modify-write.
- Initialises the table after reset and keeps branch statistics counters, replacing ad-hoc simulation stat events.

Parameters:
IDX_W, 8, PHT index width; table has 2^IDX_W entries
DEPTH, 4, feedback FIFO entries (power of 2, >=2)
CNT_W, 32, statistics counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
i_req_valid  in  1  prediction lookup request this cycle
i_req_index  in  IDX_W  lookup PHT index
o_pred_valid  out  1  prediction result valid (cycle after request)
o_pred_taken  out  1  1=TAKEN, 0=NOT_TAKEN
i_fb_valid  in  1  branch resolved in EX
i_fb_index  in  IDX_W  PHT index of resolved branch
i_fb_taken  in  1  actual outcome
i_fb_mispredict  in  1  prediction != outcome
o_tbl_en  out  1  table port access enable
o_tbl_we  out  1  write (1) / read (0)
o_tbl_addr  out  IDX_W  table address
o_tbl_wdata  out  2  counter write data
i_tbl_rdata  in  2  read data, valid the cycle after a read
o_busy  out  1  FSM not IDLE or FIFO non-empty
o_fb_count  out  $clog2(DEPTH)+1  FIFO occupancy
o_lookup_cnt  out  CNT_W  accepted lookups
o_miss_cnt  out  CNT_W  feedbacks with mispredict=1
o_drop_cnt  out  CNT_W  feedbacks dropped (FIFO full)

Behaviour:
- Reset (rst_n=0 at posedge):
  - all outputs 0;
  - FIFO flushed; stat counters 0;
  - FSM goes to INIT with sweep address 0.
  - No table access is issued in the reset cycle.
  - Reset mid-RMW abandons the pending write.
- FSM states: INIT, IDLE, RD, WR.
- INIT:
  - Each cycle writes 2'b01 (weakly not-taken) to the sweep address, then increments it.
  - Goes to IDLE after writing address 2^IDX_W-1, so INIT lasts exactly 2^IDX_W cycles.
  - Lookups do not stall INIT.
  - A lookup at cycle N during INIT gives o_pred_valid=1, o_pred_taken=0 at N+1, with no table access.
- Lookup (outside INIT):
  - Drives o_tbl_en=1, we=0, addr=i_req_index in the same cycle, combinationally.
  - o_pred_valid=1, o_pred_taken=i_tbl_rdata[1] at N+1.
  - There is no forwarding from in-flight updates; stale reads are acceptable.
- Lookups always win the port. Updates use only cycles where i_req_valid=0.
- IDLE:
  - If FIFO non-empty and no lookup: issue read of the head index, pop the head into the working register, go to RD.
  - Otherwise stay in IDLE.
- RD:
  - Capture i_tbl_rdata and compute the new counter: taken gives min(c+1,3); not-taken gives max(c-1,0).
  - Go to WR. The port is free for lookups this cycle.
- WR:
  - If i_req_valid=1, stall in WR (the port goes to the lookup).
  - Otherwise issue the write of the new counter and go to IDLE.
- Only one RMW is ever in flight, so back-to-back updates to the same index are applied sequentially and none is lost.
- FIFO:
  - Enqueue on i_fb_valid at any time, including during INIT.
  - When full, the incoming entry is dropped and o_drop_cnt increments.
  - A pop in the same cycle as enqueue-while-full frees a slot, so the entry is accepted and nothing is dropped.
  - Pointers wrap modulo DEPTH.
- Counters:
  - o_lookup_cnt increments per i_req_valid.
  - o_miss_cnt increments per i_fb_valid&i_fb_mispredict, counted even if the entry is dropped.
  - All counters saturate at all-ones.
- o_tbl_en=0 when there is no lookup and no RMW access; o_tbl_we=0 whenever o_tbl_en=0.

Test Plan:
- Reset then idle: INIT writes 2'b01 to addr 0..255 on consecutive cycles (256 writes), then IDLE; a lookup at idx 5 returns o_pred_taken=0 next cycle.
- Two feedbacks taken to idx 7, no lookups: table access sequence is R7, W2, R7, W3; a later lookup of idx 7 returns taken=1.
- Feedback pending with i_req_valid held high 3 cycles during WR: no table write for 3 cycles, then the write issues; lookup results are valid each following cycle.
- Six feedbacks in 6 consecutive cycles with lookups holding the port: first 4 accepted, last 2 dropped; o_drop_cnt=2, o_fb_count=4; with mispredict=1 on all, o_miss_cnt=6.
- FIFO full and IDLE pops in the same cycle as a new i_fb_valid: entry accepted, o_drop_cnt unchanged, o_fb_count stays 4.
- rst_n asserted in the RD cycle: no write issues; FIFO and counters are 0; INIT restarts at addr 0.
- Counter saturation: 3 not-taken feedbacks at idx 2 (initially 01) leave 00; 5 taken feedbacks leave 11.
